// File: rtl/uncache_bus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uncache_bus_arbiter_pkg                                         |
// | Desc     : Shared encodings and widths for the uncached bus arbiter.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package uncache_bus_arbiter_pkg;

    localparam int BUS_ADDR_WIDTH = 32;
    localparam int INS_WIDTH      = 32;

    typedef enum logic [1:0] {
        UBA_STATE_IDLE  = 2'd0,
        UBA_STATE_GRANT = 2'd1,
        UBA_STATE_XFER  = 2'd2,
        UBA_STATE_DONE  = 2'd3
    } uba_state_e;

    typedef enum logic {
        UBA_OWNER_M0 = 1'b0,
        UBA_OWNER_M1 = 1'b1
    } uba_owner_e;

    localparam logic REQ_AS_ENABLE    = 1'b1;
    localparam logic REQ_RW_READ      = 1'b0;
    localparam logic REQ_RW_WRITE     = 1'b1;
    localparam logic GRANT_ENABLE     = 1'b1;
    localparam logic GRANT_DISABLE    = 1'b0;
    localparam logic BUS_ERROR_ENABLE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uncache_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uncache_bus_arbiter_if                                          |
// | Desc     : Master request/response and slave bus signals of the arbiter.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface uncache_bus_arbiter_if
    import uncache_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_WIDTH,
    parameter int DATA_W = INS_WIDTH
);
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_as;
    logic              m0_rw;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_grant;
    logic              m0_done;
    logic              m0_bus_error;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic              m1_as;
    logic              m1_rw;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_grant;
    logic              m1_done;
    logic              m1_bus_error;

    logic [DATA_W-1:0] m_rdata;

    logic [ADDR_W-1:0] s_addr;
    logic              s_as;
    logic              s_rw;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W-1:0] s_rdata;
    logic              s_rdy;

    // Arbiter side: serves both masters, drives the slave bus.
    modport slave (
        input  m0_req, m0_addr, m0_as, m0_rw, m0_wdata,
        input  m1_req, m1_addr, m1_as, m1_rw, m1_wdata,
        input  s_rdata, s_rdy,
        output m0_grant, m0_done, m0_bus_error,
        output m1_grant, m1_done, m1_bus_error,
        output m_rdata, s_addr, s_as, s_rw, s_wdata
    );

    // Environment side: the two controllers plus the slave device.
    modport master (
        output m0_req, m0_addr, m0_as, m0_rw, m0_wdata,
        output m1_req, m1_addr, m1_as, m1_rw, m1_wdata,
        output s_rdata, s_rdy,
        input  m0_grant, m0_done, m0_bus_error,
        input  m1_grant, m1_done, m1_bus_error,
        input  m_rdata, s_addr, s_as, s_rw, s_wdata
    );

endinterface
`default_nettype wire

// File: rtl/uncache_bus_arbiter_timeout_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uba_timeout_counter                                             |
// | Desc     : Counts unanswered transfer cycles; flags the TIMEOUT-th one.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uba_timeout_counter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam logic [CNT_W-1:0] c_last_count = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the cycle whose increment reaches TIMEOUT, so the registered
    // error lands exactly TIMEOUT cycles after the strobe rose.
    assign expired_o = enable_i && (cnt_q == c_last_count);

endmodule
`default_nettype wire

// File: rtl/uncache_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uncache_bus_arbiter                                             |
// | Desc     : Round-robin arbiter of IF/MEM controllers onto the uncached bus.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uncache_bus_arbiter
    import uncache_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_WIDTH,
    parameter int DATA_W  = INS_WIDTH,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    uncache_bus_arbiter_if.slave bus
);
    uba_state_e        state_q, state_d;
    uba_owner_e        owner_q, owner_d;
    uba_owner_e        last_owner_q, last_owner_d;
    logic              m0_grant_q, m0_grant_d, m1_grant_q, m1_grant_d;
    logic              m0_done_q, m0_done_d, m1_done_q, m1_done_d;
    logic              m0_err_q, m0_err_d, m1_err_q, m1_err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic              s_as_q, s_as_d;
    logic              s_rw_q, s_rw_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;

    logic              cnt_clear;
    logic              cnt_en;
    logic              cnt_expired;

    logic              own_m0;
    logic              own_req;
    logic              own_as;
    logic              own_rw;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;

    assign own_m0    = (owner_q == UBA_OWNER_M0);
    assign own_req   = own_m0 ? bus.m0_req   : bus.m1_req;
    assign own_as    = own_m0 ? bus.m0_as    : bus.m1_as;
    assign own_rw    = own_m0 ? bus.m0_rw    : bus.m1_rw;
    assign own_addr  = own_m0 ? bus.m0_addr  : bus.m1_addr;
    assign own_wdata = own_m0 ? bus.m0_wdata : bus.m1_wdata;

    uba_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk       (clk),
        .resetn    (resetn),
        .clear_i   (cnt_clear),
        .enable_i  (cnt_en),
        .expired_o (cnt_expired)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        m0_grant_d   = m0_grant_q;
        m1_grant_d   = m1_grant_q;
        m0_done_d    = 1'b0;
        m1_done_d    = 1'b0;
        m0_err_d     = 1'b0;
        m1_err_d     = 1'b0;
        rdata_d      = rdata_q;
        s_addr_d     = s_addr_q;
        s_as_d       = s_as_q;
        s_rw_d       = s_rw_q;
        s_wdata_d    = s_wdata_q;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;

        case (state_q)
            UBA_STATE_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    // M0 takes it alone, or on a tie when M1 owned the bus last.
                    if (bus.m0_req && (!bus.m1_req || last_owner_q == UBA_OWNER_M1)) begin
                        owner_d    = UBA_OWNER_M0;
                        m0_grant_d = GRANT_ENABLE;
                    end else begin
                        owner_d    = UBA_OWNER_M1;
                        m1_grant_d = GRANT_ENABLE;
                    end
                    state_d = UBA_STATE_GRANT;
                end
            end
            UBA_STATE_GRANT: begin
                if (own_as == REQ_AS_ENABLE) begin
                    s_addr_d  = own_addr;
                    s_rw_d    = own_rw;
                    s_wdata_d = own_wdata;
                    s_as_d    = 1'b1;
                    cnt_clear = 1'b1;
                    state_d   = UBA_STATE_XFER;
                end else if (!own_req) begin
                    m0_grant_d = GRANT_DISABLE;
                    m1_grant_d = GRANT_DISABLE;
                    state_d    = UBA_STATE_IDLE;
                end
            end
            UBA_STATE_XFER: begin
                if (bus.s_rdy) begin
                    if (s_rw_q == REQ_RW_READ) begin
                        rdata_d = bus.s_rdata;
                    end
                    m0_done_d = own_m0;
                    m1_done_d = !own_m0;
                    s_as_d    = 1'b0;
                    state_d   = UBA_STATE_DONE;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_expired) begin
                        m0_err_d = own_m0 ? BUS_ERROR_ENABLE : 1'b0;
                        m1_err_d = own_m0 ? 1'b0 : BUS_ERROR_ENABLE;
                        s_as_d   = 1'b0;
                        state_d  = UBA_STATE_DONE;
                    end
                end
            end
            UBA_STATE_DONE: begin
                m0_grant_d   = GRANT_DISABLE;
                m1_grant_d   = GRANT_DISABLE;
                last_owner_d = owner_q;
                state_d      = UBA_STATE_IDLE;
            end
            default: begin
                state_d = UBA_STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= UBA_STATE_IDLE;
            owner_q      <= UBA_OWNER_M0;
            last_owner_q <= UBA_OWNER_M1;
            m0_grant_q   <= GRANT_DISABLE;
            m1_grant_q   <= GRANT_DISABLE;
            m0_done_q    <= 1'b0;
            m1_done_q    <= 1'b0;
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
            rdata_q      <= '0;
            s_addr_q     <= '0;
            s_as_q       <= 1'b0;
            s_rw_q       <= REQ_RW_READ;
            s_wdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            m0_grant_q   <= m0_grant_d;
            m1_grant_q   <= m1_grant_d;
            m0_done_q    <= m0_done_d;
            m1_done_q    <= m1_done_d;
            m0_err_q     <= m0_err_d;
            m1_err_q     <= m1_err_d;
            rdata_q      <= rdata_d;
            s_addr_q     <= s_addr_d;
            s_as_q       <= s_as_d;
            s_rw_q       <= s_rw_d;
            s_wdata_q    <= s_wdata_d;
        end
    end

    assign bus.m0_grant     = m0_grant_q;
    assign bus.m1_grant     = m1_grant_q;
    assign bus.m0_done      = m0_done_q;
    assign bus.m1_done      = m1_done_q;
    assign bus.m0_bus_error = m0_err_q;
    assign bus.m1_bus_error = m1_err_q;
    assign bus.m_rdata      = rdata_q;
    assign bus.s_addr       = s_addr_q;
    assign bus.s_as         = s_as_q;
    assign bus.s_rw         = s_rw_q;
    assign bus.s_wdata      = s_wdata_q;

endmodule
`default_nettype wire
